// File: rtl/multdiv_seq.sv
// Iterative signed multiply (Booth) / divide (restoring) with start pulse, one-cycle ready pulse, flush and exceptions.
// Define MULTDIV_RADIX4_EN for radix-4 Booth multiply (WIDTH/2 steps); otherwise radix-2 (WIDTH steps).
module multdiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_flush,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef MULTDIV_RADIX4_EN
  localparam int MUL_STEPS = WIDTH / 2;
`else
  localparam int MUL_STEPS = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             div_q, neg_q, dz_q, dovf_q, qm1_q;
  logic [WIDTH-1:0] m_q, lo_q;
  logic [WIDTH+1:0] hi_q;

  logic             start;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH+1:0] m_ext, pp, sum, hi_d;
  logic [WIDTH-1:0] lo_d, quot, fin_res;
  logic             qm1_d, fin_exc;
  logic [WIDTH:0]   trial;
  logic [2*WIDTH-1:0] prod;

  assign start = ctrl_MULT | ctrl_DIV;
  assign abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // hi_q carries two guard bits so +-2M partial sums never overflow
  always_comb begin
    m_ext = {{2{m_q[WIDTH-1]}}, m_q};
    pp    = '0;
`ifdef MULTDIV_RADIX4_EN
    case ({lo_q[1:0], qm1_q})
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_ext << 1;
      3'b100:         pp = -(m_ext << 1);
      3'b101, 3'b110: pp = -m_ext;
      default:        pp = '0;
    endcase
    sum   = hi_q + pp;
    hi_d  = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    lo_d  = {sum[1:0], lo_q[WIDTH-1:2]};
    qm1_d = lo_q[1];
`else
    case ({lo_q[0], qm1_q})
      2'b01:   pp = m_ext;
      2'b10:   pp = -m_ext;
      default: pp = '0;
    endcase
    sum   = hi_q + pp;
    hi_d  = {sum[WIDTH+1], sum[WIDTH+1:1]};
    lo_d  = {sum[0], lo_q[WIDTH-1:1]};
    qm1_d = lo_q[0];
`endif
    // Divide: hi_q holds the partial remainder, lo_q shifts dividend out and quotient in
    trial = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]} - {1'b0, m_q};
    if (div_q) begin
      hi_d = '0;
      hi_d[WIDTH-1:0] = trial[WIDTH] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : trial[WIDTH-1:0];
      lo_d  = {lo_q[WIDTH-2:0], ~trial[WIDTH]};
      qm1_d = 1'b0;
    end

    prod = {hi_q[WIDTH-1:0], lo_q};
    quot = neg_q ? -lo_q : lo_q;
    if (div_q) begin
      fin_res = dz_q ? '0 : quot;
      fin_exc = dz_q | dovf_q;
    end else begin
      fin_res = prod[WIDTH-1:0];
      fin_exc = prod[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod[WIDTH-1]}};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      div_q          <= 1'b0;
      neg_q          <= 1'b0;
      dz_q           <= 1'b0;
      dovf_q         <= 1'b0;
      qm1_q          <= 1'b0;
      m_q            <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        state_q <= RUN;
        busy    <= 1'b1;
        div_q   <= ~ctrl_MULT;
        cnt_q   <= ctrl_MULT ? CW'(MUL_STEPS) : CW'(WIDTH);
        hi_q    <= '0;
        qm1_q   <= 1'b0;
        m_q     <= ctrl_MULT ? data_operandA : abs_b;
        lo_q    <= ctrl_MULT ? data_operandB : abs_a;
        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_q    <= data_operandB == '0;
        dovf_q  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end else if (ctrl_flush || state_q == DONE) begin
        state_q <= IDLE;
        busy    <= 1'b0;
      end else if (state_q == RUN) begin
        if (cnt_q == '0) begin
          state_q        <= DONE;
          data_result    <= fin_res;
          data_exception <= fin_exc;
          data_resultRDY <= 1'b1;
        end else begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q - CW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_multdiv_seq.sv
// Randomised and directed bench for multdiv_seq against an arithmetic reference model.
module tb_multdiv_seq;
  localparam int W = 32;
`ifdef MULTDIV_RADIX4_EN
  localparam int LAT_MUL = W / 2 + 1;
`else
  localparam int LAT_MUL = W + 1;
`endif
  localparam int LAT_DIV = W + 1;

  logic         clock, reset, ctrl_MULT, ctrl_DIV, ctrl_flush;
  logic [W-1:0] data_operandA, data_operandB, data_result;
  logic         data_exception, data_resultRDY, busy;
  int           n_pass, n_total;

  multdiv_seq #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .ctrl_flush(ctrl_flush),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint p;
    int     q;
    r = '0;
    e = 1'b0;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      e = (p != longint'($signed(p[W-1:0])));
    end else if (b == 0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
    end
  endfunction

  task automatic issue(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = ~is_div;
    ctrl_DIV  = is_div;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // k counts negedges after the start edge; the pulse is due at k == lat
  task automatic wait_done(input string tag, input int lat, input logic [W-1:0] er, input logic ee);
    int k;
    for (k = 0; k <= lat + 4; k++) begin
      @(negedge clock);
      if (k == 0) check({tag, ".busy_rise"}, busy, 1);
      if (data_resultRDY) break;
    end
    check({tag, ".lat"}, k, lat);
    check({tag, ".res"}, data_result, er);
    check({tag, ".exc"}, data_exception, ee);
    @(negedge clock);
    check({tag, ".rdy_fall"}, data_resultRDY, 0);
    check({tag, ".busy_fall"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic         ee;
    model(is_div, a, b, er, ee);
    issue(is_div, a, b);
    wait_done(tag, is_div ? LAT_DIV : LAT_MUL, er, ee);
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 4))
      0: v = W'($urandom_range(0, 40)) - W'(20);
      1: v = 32'h8000_0000;
      2: v = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      3: v = W'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int rdy_seen;
    logic [W-1:0] ra, rb;
    logic rdiv;
    n_pass = 0;
    n_total = 0;
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    ctrl_flush = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1 reset = 1'b1;
    #1;
    check("rst.res", data_result, 0);
    check("rst.exc", data_exception, 0);
    check("rst.rdy", data_resultRDY, 0);
    check("rst.busy", busy, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    run_op("mul6x7", 1'b0, 32'd6, 32'd7);
    run_op("mul_ovf", 1'b0, 32'h7FFF_FFFF, 32'd2);
    run_op("mul_neg", 1'b0, -32'sd3, 32'd5);
    run_op("div_neg", 1'b1, -32'sd8, 32'd3);
    run_op("div_zero", 1'b1, 32'd5, 32'd0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // restart: a multiply at edge 10 abandons the running divide
    rdy_seen = 0;
    issue(1'b1, 32'd100, 32'd7);
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    issue(1'b0, 32'd3, 32'd4);
    check("restart.no_pulse", rdy_seen, 0);
    wait_done("restart", LAT_MUL, 32'd12, 1'b0);

    // flush at edge 5 keeps the previous result (12)
    rdy_seen = 0;
    issue(1'b0, 32'd9, 32'd9);
    repeat (4) @(negedge clock);
    @(negedge clock);
    ctrl_flush = 1'b1;
    @(posedge clock);
    #1 ctrl_flush = 1'b0;
    repeat (LAT_MUL + 4) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    check("flush.no_pulse", rdy_seen, 0);
    check("flush.busy", busy, 0);
    check("flush.res", data_result, 12);
    check("flush.exc", data_exception, 0);

    // asynchronous reset in the middle of a run
    issue(1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (5) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst.res", data_result, 0);
    check("arst.exc", data_exception, 0);
    check("arst.rdy", data_resultRDY, 0);
    check("arst.busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
    run_op("post_rst", 1'b0, -32'sd11, -32'sd13);

    for (int i = 0; i < 40; i++) begin
      rdiv = $urandom_range(0, 1) == 1;
      ra = pick_operand();
      rb = pick_operand();
      run_op(rdiv ? "rand_div" : "rand_mul", rdiv, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
